// File: rtl/muldiv_pkg.sv
// Shared encodings for the sequential multiply/divide unit.
// Holds op codes, FSM states and the iteration-counter width helper.
package muldiv_pkg;

  localparam logic [1:0] OP_MTHI = 2'b00;
  localparam logic [1:0] OP_MTLO = 2'b01;
  localparam logic [1:0] OP_MUL  = 2'b10;
  localparam logic [1:0] OP_DIV  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PREP = 2'd1,
    S_RUN  = 2'd2,
    S_FIX  = 2'd3
  } state_e;

  // Counter must hold the value WIDTH itself, hence the extra bit.
  function automatic int cnt_w(input int w);
    return $clog2(w) + 1;
  endfunction

endpackage

// File: rtl/muldiv_iter_core.sv
// Iterative datapath: 2*WIDTH accumulator shared by shift-add multiply
// (hi half = partial sum) and restoring divide (hi = remainder, lo = quotient).
module muldiv_iter_core
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load,
  input  logic                 step,
  input  logic                 is_div,
  input  logic [WIDTH-1:0]     a_in,
  input  logic [WIDTH-1:0]     b_in,
  output logic [2*WIDTH-1:0]   acc
);

  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     shifted;
  logic               ge;

  always_comb begin
    acc_d   = acc_q;
    b_d     = b_q;
    sum     = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, b_q} : '0);
    shifted = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    ge      = (shifted >= {1'b0, b_q});
    if (load) begin
      acc_d = {{WIDTH{1'b0}}, a_in};
      b_d   = b_in;
    end else if (step) begin
      // A successful trial subtract always leaves a remainder below 2^WIDTH.
      if (is_div)
        acc_d = {(ge ? (shifted[WIDTH-1:0] - b_q) : shifted[WIDTH-1:0]),
                 acc_q[WIDTH-2:0], ge};
      else
        acc_d = {sum, acc_q[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_q <= '0;
      b_q   <= '0;
    end else begin
      acc_q <= acc_d;
      b_q   <= b_d;
    end
  end

  assign acc = acc_q;

endmodule

// File: rtl/muldiv_seq_hilo.sv
// Multi-cycle MULT/DIV unit owning HI/LO, with a stalling MFHI/MFLO read port.
// Optional MULDIV_EARLY_EXIT_EN skips iteration for zero operands / zero divisor.
module muldiv_seq_hilo
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             sin,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] in_1,
  input  logic [WIDTH-1:0] in_2,
  output logic             busy,
  input  logic             rd_req,
  input  logic             rd_sel,
  output logic             stall,
  output logic             rd_valid,
  output logic [WIDTH-1:0] rd_data,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = cnt_w(WIDTH);

  function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] x);
    return (~x) + WIDTH'(1);
  endfunction

  function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] x);
    return (~x) + (2*WIDTH)'(1);
  endfunction

  // -2^(WIDTH-1) maps to 2^(WIDTH-1), which still fits as an unsigned magnitude.
  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x, input logic en);
    return (en && x[WIDTH-1]) ? neg_w(x) : x;
  endfunction

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
  logic               sin_q, sin_d;
  logic               div_q, div_d;
  logic               negq_q, negq_d;
  logic               negr_q, negr_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic               rd_valid_q, rd_valid_d;
  logic [WIDTH-1:0]   rd_data_q, rd_data_d;
  logic               core_load, core_step, rd_acc, b_zero;
  logic [2*WIDTH-1:0] core_acc;
`ifdef MULDIV_EARLY_EXIT_EN
  logic               a_zero;
  assign a_zero = (a_q == '0);
`endif

  assign b_zero = (b_q == '0);
  assign busy   = (state_q != S_IDLE);
  assign stall  = rd_req & (busy | start);
  assign rd_acc = rd_req & ~stall;

  muldiv_iter_core #(.WIDTH(WIDTH)) u_core (
    .clk    (clk),
    .reset  (reset),
    .load   (core_load),
    .step   (core_step),
    .is_div (div_q),
    .a_in   (mag(a_q, sin_q)),
    .b_in   (mag(b_q, sin_q)),
    .acc    (core_acc)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    a_d        = a_q;
    b_d        = b_q;
    sin_d      = sin_q;
    div_d      = div_q;
    negq_d     = negq_q;
    negr_d     = negr_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    core_load  = 1'b0;
    core_step  = 1'b0;
    rd_valid_d = rd_acc;
    rd_data_d  = rd_acc ? (rd_sel ? hi_q : lo_q) : rd_data_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          case (op)
            OP_MTHI: hi_d = in_1;
            OP_MTLO: lo_d = in_1;
            default: begin
              a_d     = in_1;
              b_d     = in_2;
              sin_d   = sin;
              div_d   = op[0];
              state_d = S_PREP;
            end
          endcase
        end
      end
      S_PREP: begin
        core_load = 1'b1;
        negq_d    = sin_q & (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
        negr_d    = sin_q & a_q[WIDTH-1];
        cnt_d     = CW'(WIDTH);
        state_d   = S_RUN;
`ifdef MULDIV_EARLY_EXIT_EN
        if (div_q ? b_zero : (a_zero | b_zero))
          state_d = S_FIX;
`endif
      end
      S_RUN: begin
        core_step = 1'b1;
        cnt_d     = cnt_q - CW'(1);
        if (cnt_q == CW'(1))
          state_d = S_FIX;
      end
      S_FIX: begin
        state_d = S_IDLE;
        if (div_q) begin
          lo_d = negq_q ? neg_w(core_acc[WIDTH-1:0]) : core_acc[WIDTH-1:0];
          hi_d = negr_q ? neg_w(core_acc[2*WIDTH-1:WIDTH]) : core_acc[2*WIDTH-1:WIDTH];
          if (b_zero) begin
            lo_d = '1;
            hi_d = a_q;
          end
        end else begin
          {hi_d, lo_d} = negq_q ? neg_2w(core_acc) : core_acc;
`ifdef MULDIV_EARLY_EXIT_EN
          // Skipped iterations leave the multiplicand in the accumulator.
          if (a_zero | b_zero) begin
            hi_d = '0;
            lo_d = '0;
          end
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      a_q        <= '0;
      b_q        <= '0;
      sin_q      <= 1'b0;
      div_q      <= 1'b0;
      negq_q     <= 1'b0;
      negr_q     <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      a_q        <= a_d;
      b_q        <= b_d;
      sin_q      <= sin_d;
      div_q      <= div_d;
      negq_q     <= negq_d;
      negr_q     <= negr_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
    end
  end

  assign hi       = hi_q;
  assign lo       = lo_q;
  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_data_q;

endmodule

// File: doc/muldiv_seq_hilo.md
Name: muldiv_seq_hilo

Overview:
- Multi-cycle multiply/divide unit that owns the HI/LO architectural registers.
- Exposes a write side (MTHI/MTLO/MULT/DIV issue, one op at a time) and a read side (MFHI/MFLO requests with a stall handshake).
- Sits beside the ALU in the execute stage.
- Replaces single-cycle mult/div with a 32-iteration shift-add / restoring-divide datapath, so the pipeline's MFHI/MFLO reads must stall until results land.

Parameters:
- WIDTH, 32, operand width; HI and LO are each WIDTH bits; iteration count = WIDTH.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- start  input  1  issue request; sampled only when busy=0
- sin  input  1  1 = signed MULT/DIV, 0 = unsigned
- op  input  2  00 MTHI, 01 MTLO, 10 MULT(U), 11 DIV(U)
- in_1  input  WIDTH  rs operand: multiplicand/dividend, or MTHI/MTLO data
- in_2  input  WIDTH  rt operand: multiplier/divisor
- busy  output  1  iterative op in flight
- rd_req  input  1  MFHI/MFLO request
- rd_sel  input  1  0 = LO, 1 = HI
- stall  output  1  combinational; rd_req not accepted this cycle
- rd_valid  output  1  registered; rd_data valid this cycle
- rd_data  output  WIDTH  registered read data
- hi  output  WIDTH  HI register
- lo  output  WIDTH  LO register

Behaviour:
- Reset (reset=0, async): state IDLE; busy, rd_valid, rd_data, hi, lo, and all datapath registers = 0. Reset mid-operation aborts the op with no partial write.
- FSM: IDLE -> PREP (1 cycle) -> RUN (WIDTH cycles) -> FIX (1 cycle) -> IDLE.
- busy=1 in PREP, RUN and FIX.
- Issue with start=1 in IDLE:
  - op 00/01: hi/lo <= in_1 at that edge; FSM stays IDLE.
  - op 10/11: operands latched, FSM -> PREP.
- PREP: take magnitudes if sin=1 (mag(x) = x[MSB] ? -x : x, computed in WIDTH+1 bits). Record the sign of the product/quotient (XOR of operand signs) and the remainder sign (dividend sign). Clear the accumulator and load counter = WIDTH.
- RUN:
  - MULT: one shift-add step per cycle into a 2*WIDTH-bit accumulator.
  - DIV: one restoring step per cycle (shift partial remainder left, trial-subtract divisor, set quotient bit if non-negative).
  - Counter decrements each cycle; exit when it reaches 1.
- FIX: apply signs (two's-complement negate) and write hi/lo; busy falls at the same edge. Total: 2+WIDTH edges from accept to hi/lo update (34 at default).
- Results:
  - MULT: {hi, lo} = full 2*WIDTH-bit product.
  - DIV: lo = quotient truncated toward zero; hi = remainder with the dividend's sign.
  - Signed -2^31 / -1: lo = 0x80000000, hi = 0.
  - Divide by zero (any sin): lo = all-ones, hi = in_1 unmodified. Still takes full latency unless the optional feature below is enabled.
- start while busy=1: ignored. The issuer holds start until busy=0.
- Read side:
  - stall = rd_req & (busy | start). A write in the same cycle has priority over a read.
  - On an accepted read, the next edge sets rd_valid=1 and rd_data = rd_sel ? hi : lo (post-write value).
  - rd_valid deasserts the following cycle unless another read is accepted.
  - Back-to-back accepted reads give one valid per cycle.
- hi/lo change only at MTHI/MTLO issue, at FIX, or at reset.

Optional Feature:
- Macro MULDIV_EARLY_EXIT_EN.
- Defined: in PREP, if either MULT operand is 0, or the DIV divisor is 0, skip RUN and go to FIX. Result is written 2 edges after accept.
  - Zero product gives hi = lo = 0.
  - Divide by zero gives the values above.
- Undefined: every MULT/DIV takes the full 2+WIDTH edges.

Decomposition:
- Package muldiv_pkg:
  - op encoding constants (OP_MTHI, OP_MTLO, OP_MUL, OP_DIV).
  - State enum (S_IDLE, S_PREP, S_RUN, S_FIX).
  - Helper constant for the counter width, $clog2(WIDTH)+1.
- One sub-module, muldiv_iter_core: accumulator/remainder/quotient shift registers plus the one-step add/subtract logic, controlled by load/step signals.
- Top level keeps the FSM, sign handling, HI/LO registers and read port.

Test Plan:
- MULT sin=1, in_1=0xFFFFFFFD (-3), in_2=7 -> busy high for 34 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- DIV sin=1, in_1=-7, in_2=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - DIVU 0xFFFFFFFF / 0x10 -> lo=0x0FFFFFFF, hi=0xF.
  - DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIV in_1=5, in_2=0 -> lo=0xFFFFFFFF, hi=5.
  - With MULDIV_EARLY_EXIT_EN defined: busy for exactly 2 cycles.
- Issue MULT 6*7, then hold rd_req=1, rd_sel=0 -> stall=1 while busy; accepted the cycle busy=0; next cycle rd_valid=1, rd_data=42.
- MTHI in_1=0x12345678 with rd_req=1, rd_sel=1 in the same cycle -> stall=1 that cycle; next cycle accepted; rd_data=0x12345678.
- Drive reset=0 at RUN cycle 10 of a DIV -> immediately busy=0, hi=lo=0, rd_valid=0. After release, a fresh MULT 3*3 gives lo=9.
